pc_sequencer: RTL

- Owns the architectural program counter register and computes the next PC every cycle.
- Generalises the branch-target adder into a parametrised, registered next-PC unit with four redirect sources: sequential, branch, jump/JAL, and JR/return.
- Also provides exception redirect, a misaligned-target trap, stall, and a small return-address stack (RAS).
- Sits between the control/decode logic and the instruction-memory address port.

---
 rtl/pc_pkg.sv | 13 +
 rtl/ras_stack.sv | 47 ++++
 rtl/pc_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared next-PC select encoding and instruction-format constants for the PC sequencer.
package pc_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int JIDX_W      = 26;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_JR,
    SEL_EXC
  } sel_e;
endpackage

// File: rtl/ras_stack.sv
// Circular return-address LIFO; push/pop take effect on the clock edge, top/count are registered.
// A push when full overwrites the oldest entry and sets a sticky overflow flag.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_dat,
  output logic [WIDTH-1:0]           top_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_inc;

  assign top_inc = top + PW'(1);
  assign top_dat = mem[top];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[top_inc] <= push_dat;
      top          <= top_inc;
      // Full stack: the slot after top is the oldest entry, so it is simply overwritten.
      if (full) ovf   <= 1'b1;
      else      count <= count + CW'(1);
    end else if (pop && !empty) begin
      top   <= top - PW'(1);
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register with prioritised next-PC select, exception/misalign redirect and RAS.
// One-cycle latency from qualifying inputs to pc_o; stall_i holds PC and RAS unless exc_i is set.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              exc_i,
  input  logic              branch_i,
  input  logic              taken_i,
  input  logic [15:0]       imm_i,
  input  logic              jump_i,
  input  logic              link_i,
  input  logic [JIDX_W-1:0] jidx_i,
  input  logic              jr_i,
  input  logic              ret_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [ADDR_W-1:0] link_addr_o,
  output logic              misalign_o,
  output logic              ras_ovf_o,
  output logic              ras_unf_o
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(EXC_VECTOR);
  // Jump keeps the PC region above the 28-bit word-index window.
  localparam logic [ADDR_W-1:0] JMP_HI_MASK = ~ADDR_W'({(JIDX_W+2){1'b1}});

  logic [ADDR_W-1:0] seq, br_tgt, jmp_tgt, jr_tgt, imm_ofs, pc_nxt, ras_top;
  logic [CW-1:0]     ras_count;
  logic              ras_full, ras_empty, unused_ras;
  logic              act, ret_hit, jr_mis, do_push, do_pop, mis_nxt, unf_nxt;
  sel_e              sel;

  assign seq         = pc_o + ADDR_W'(INSTR_BYTES);
  assign pc_plus4_o  = seq;
  assign link_addr_o = seq;
  assign imm_ofs     = {{(ADDR_W-18){imm_i[15]}}, imm_i, 2'b00};
  assign br_tgt      = seq + imm_ofs;
  assign jmp_tgt     = (seq & JMP_HI_MASK) | ADDR_W'({jidx_i, 2'b00});
  assign ret_hit     = ret_i & ~ras_empty;
  assign jr_tgt      = ret_hit ? ras_top : jr_target_i;
  assign jr_mis      = (jr_tgt[1:0] != 2'b00);
  assign unused_ras  = ^{ras_count, ras_full};

  // Side effects belong only to a winning, non-stalled, non-excepted source.
  assign act     = ~stall_i & ~exc_i;
  assign do_push = act & ~jr_i & jump_i & link_i;
  assign do_pop  = act & jr_i & ret_hit;
  assign mis_nxt = act & jr_i & jr_mis;
  assign unf_nxt = act & jr_i & ret_i & ras_empty;

  always_comb begin
    sel = SEL_SEQ;
    if (exc_i)                    sel = SEL_EXC;
    else if (jr_i)                sel = SEL_JR;
    else if (jump_i)              sel = SEL_JMP;
    else if (branch_i && taken_i) sel = SEL_BR;
  end

  always_comb begin
    pc_nxt = seq;
    case (sel)
      SEL_EXC: pc_nxt = EXC_VEC;
      SEL_JR:  pc_nxt = jr_mis ? EXC_VEC : jr_tgt;
      SEL_JMP: pc_nxt = jmp_tgt;
      SEL_BR:  pc_nxt = br_tgt;
      default: pc_nxt = seq;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o       <= RST_PC;
      misalign_o <= 1'b0;
      ras_unf_o  <= 1'b0;
    end else begin
      if (exc_i || !stall_i) pc_o <= pc_nxt;
      misalign_o <= mis_nxt;
      ras_unf_o  <= unf_nxt;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (do_push),
    .pop      (do_pop),
    .push_dat (seq),
    .top_dat  (ras_top),
    .count    (ras_count),
    .full     (ras_full),
    .empty    (ras_empty),
    .ovf      (ras_ovf_o)
  );
endmodule
